// File: rtl/sr_rom_loader_pkg.sv
// Shared definitions for the UART-fed ROM loader: FSM encoding,
// default frame header byte and data byte-index sizing.
// Imported by the loader top and its timeout sub-module.
package sr_rom_loader_pkg;

  // Loader sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } state_t;

  // Default frame header byte.
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Byte index within a 32-bit word (little-endian, 4 bytes).
  localparam int unsigned BIDX_W = 2;
  localparam logic [BIDX_W-1:0] LAST_BIDX = 2'd3;

endpackage

// File: rtl/sr_rom_loader_timeout.sv
// Loadable down-counter with enable and a one-cycle expiry pulse.
// Expiry is combinational: asserted in the cycle the count would reach zero.
// A load in the same cycle suppresses expiry (fresh activity wins).
module sr_rom_loader_timeout #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = en && !load && (cnt == W'(1));

  // Reload on activity, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sr_rom_loader.sv
// UART-fed program loader: parses SYNC/LEN/DATA/CSUM frames, writes
// little-endian 32-bit words to ROM and holds the CPU in reset while loading.
// ROM write appears one cycle after the 4th byte of each word.
module sr_rom_loader
  import sr_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  // Largest legal word count; compared in 17 bits so a 16-bit length never overflows.
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t              state;
  logic [15:0]         len;
  logic [CNT_W-1:0]    word_cnt;
  logic [BIDX_W-1:0]   byte_idx;
  logic [23:0]         asm_word;   // bytes 0..2; byte 3 goes straight to the write register
  logic [7:0]          xsum;
  logic                to_expired;
  logic [16:0]         len_in;

  // Full 16-bit length as it becomes known in LEN_HI.
  assign len_in = {1'b0, rx_data, len[7:0]};

  sr_rom_loader_timeout #(
    .W (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_valid),
    .load_val (TO_W'(TIMEOUT)),
    .en       (state != ST_IDLE),
    .expired  (to_expired)
  );

  // Frame sequencer with registered outputs; errors return to IDLE with CPU still held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      asm_word  <= '0;
      xsum      <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      done   <= 1'b0;
      if (to_expired) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= ST_LEN_LO;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              err      <= 1'b0;
              word_cnt <= '0;
              byte_idx <= '0;
              xsum     <= '0;
            end
          end
          ST_LEN_LO: begin
            len[7:0] <= rx_data;
            state    <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len[15:8] <= rx_data;
            if (len_in > DEPTH) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else if (len_in == 17'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            xsum     <= xsum ^ rx_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_BIDX) begin
              rom_we    <= 1'b1;
              rom_wdata <= {rx_data, asm_word};
              rom_addr  <= word_cnt[ADDR_W-1:0];
              word_cnt  <= word_cnt + 1'b1;
              if ((17'(word_cnt) + 17'd1) == {1'b0, len}) begin
                state <= ST_CSUM;
              end
            end else begin
              asm_word[8*byte_idx +: 8] <= rx_data;
            end
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (rx_data == xsum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_rom_loader.sv
// Directed bench for sr_rom_loader (ADDR_W=2, TIMEOUT=50) with a write scoreboard.
// Expected ROM writes are queued as frames are driven and popped by a monitor.
// Covers normal, back-to-back, bad checksum, full-depth, oversize, timeout and reset.
module tb_sr_rom_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned TO = 50;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  int  checks;
  int  errors;
  int  we_cnt;
  int  done_cnt;
  wr_t exp_q[$];
  logic [31:0] prog [4];

  sr_rom_loader #(
    .ADDR_W    (AW),
    .TIMEOUT   (TO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ROM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wr_t e;
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(rom_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rom_addr), 32'(e.addr));
        chk("wr_data", rom_wdata, e.data);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte for exactly one active edge; returns 1 time unit after that edge.
  task automatic put(input logic [7:0] b, input bit b2b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!b2b) idle(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(rom_we),    32'd0);
    chk({tag, "_addr"},  32'(rom_addr),  32'd0);
    chk({tag, "_wdata"}, rom_wdata,      32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_err"},   32'(err),       32'd0);
  endtask

  // Drive one frame of n words from prog[]; b2b keeps rx_valid high every cycle.
  task automatic load(input string tag, input int n, input bit b2b, input bit bad_cs);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    logic [15:0] n16;
    int          we0;
    cs  = 8'h00;
    we0 = we_cnt;
    n16 = 16'(n);
    put(8'hA5, b2b);
    if (!b2b) begin
      chk({tag, "_busy_on"}, 32'(busy), 32'd1);
      chk({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
    end
    put(n16[7:0], b2b);
    put(n16[15:8], b2b);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      exp_q.push_back('{addr: AW'(i), data: w});
      for (int j = 0; j < 4; j++) begin
        b  = w[8*j +: 8];
        cs = cs ^ b;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (j == 3) begin
          chk({tag, "_we_latency"}, 32'(rom_we), 32'd1);
          chk({tag, "_we_addr"}, 32'(rom_addr), 32'(i));
        end
        if (!b2b) idle(1);
      end
    end
    if (bad_cs) cs = cs ^ 8'h01;
    rx_data  = cs;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), bad_cs ? 32'd0 : 32'd1);
    chk({tag, "_err"}, 32'(err), bad_cs ? 32'd1 : 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), bad_cs ? 32'd1 : 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    idle(1);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_writes"}, 32'(we_cnt - we0), 32'(n));
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    checks   = 0;
    errors   = 0;
    we_cnt   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    prog[0]  = 32'h0010_0513;
    prog[1]  = 32'h0020_0593;
    prog[2]  = 32'hA5A5_A5A5;
    prog[3]  = 32'hDEAD_BEEF;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Stray bytes in IDLE are ignored.
    put(8'h13, 1'b0);
    put(8'h00, 1'b0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // Reference two-word program with gaps, then back-to-back.
    load("n2_gap", 2, 1'b0, 1'b0);
    chk("addr_hold", 32'(rom_addr), 32'd1);
    load("n2_b2b", 2, 1'b1, 1'b0);

    // Bad checksum, then recovery frame.
    load("bad_cs", 2, 1'b0, 1'b1);
    idle(3);
    chk("bad_cs_hold_stays", 32'(cpu_hold), 32'd1);
    load("recover", 2, 1'b0, 1'b0);

    // Full depth: N == 2**ADDR_W writes the last address; sync byte inside data.
    load("full_depth", 4, 1'b1, 1'b0);
    chk("full_depth_last_addr", 32'(rom_addr), 32'd3);

    // Oversize length aborts right after LEN_HI with no writes.
    we0 = we_cnt;
    put(8'hA5, 1'b0);
    put(8'h05, 1'b0);
    put(8'h00, 1'b1);
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_busy", 32'(busy), 32'd0);
    chk("oversize_hold", 32'(cpu_hold), 32'd1);
    idle(4);
    chk("oversize_writes", 32'(we_cnt - we0), 32'd0);

    // Timeout: silence after the 2nd data byte; err exactly TO cycles later.
    put(8'hA5, 1'b0);
    chk("to_err_clr", 32'(err), 32'd0);
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    put(8'h11, 1'b0);
    put(8'h22, 1'b1);
    idle(TO - 1);
    chk("to_not_yet", 32'(err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    idle(1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    put(8'h33, 1'b0);
    put(8'h44, 1'b0);
    chk("to_ignore_busy", 32'(busy), 32'd0);
    chk("to_ignore_err", 32'(err), 32'd1);
    chk("to_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA clears everything.
    put(8'hA5, 1'b0);
    put(8'h01, 1'b0);
    put(8'h00, 1'b0);
    put(8'h11, 1'b0);
    rst = 1'b1;
    idle(1);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    idle(1);

    // Empty frame after reset: done, no writes.
    load("n0", 0, 1'b0, 1'b0);

    chk("done_total", 32'(done_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_rom_loader.md
Name: sr_rom_loader

Overview:
- UART-fed program loader. Takes a framed byte stream from the UART receiver, assembles 32-bit little-endian words and writes them into the instruction ROM.
- Holds the CPU in reset for the whole load.
- Sits in sm_top between the UART RX byte interface and the ROM write port / CPU reset gating. It is the sequencer that replaces manual romWrite_i loading.

Parameters:
- ADDR_W, 8, ROM word-address width; ROM depth = 2**ADDR_W words.
- TIMEOUT, 1000000, max idle cycles between bytes inside a frame before abort.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle; may assert on consecutive cycles.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM word address.
- rom_wdata  out  32  ROM write data.
- cpu_hold  out  1  1 = keep CPU in reset.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on successful frame end.
- err  out  1  sticky error flag.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values (also when rst asserts mid-frame): state IDLE, rom_we=0, rom_addr=0, rom_wdata=0, cpu_hold=0, busy=0, done=0, err=0, all counters 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (word count N, 16 bit), 4*N data bytes (each word LSB first), CSUM. CSUM = XOR of all 4*N data bytes (0 if N=0).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM.
- IDLE:
  - rx_valid && rx_data==SYNC_BYTE -> LEN_LO; next cycle busy=1, cpu_hold=1, err cleared, word address counter=0, xor=0.
  - Other bytes are ignored.
- LEN_LO: on byte, latch len[7:0] -> LEN_HI.
- LEN_HI: on byte, latch len[15:8], then:
  - N > 2**ADDR_W -> error.
  - N == 0 -> CSUM.
  - else -> DATA.
- DATA: byte index 0..3 places the byte at [8*i+7:8*i] of the assembly register; xor ^= byte. On index 3:
  - The next cycle drives rom_we=1, rom_wdata = assembled word, rom_addr = word counter. Latency: 4th byte strobe -> rom_we exactly 1 cycle later.
  - Word counter then increments.
  - After word N-1 is captured -> CSUM.
  - The write register is separate from the assembly register, so a back-to-back byte in the rom_we cycle is accepted without loss.
- CSUM, on byte:
  - match -> IDLE, done pulse 1 cycle, busy=0, cpu_hold=0.
  - mismatch -> error.
- Error (oversize length, checksum mismatch, timeout): next cycle -> IDLE, err=1, busy=0, cpu_hold stays 1.
  - The CPU remains held with a partial program until the next successful frame or rst.
  - err clears when the next SYNC_BYTE is accepted.
- Timeout: cycle counter clears on every rx_valid and counts while state != IDLE. Reaching TIMEOUT -> error. Inactive in IDLE.
- Address wrap: rom_addr never exceeds 2**ADDR_W-1 because of the length check. N == 2**ADDR_W is legal and writes the last address.
- SYNC_BYTE inside LEN/DATA/CSUM is treated as ordinary data (no resync).
- rom_addr holds its last value when rom_we=0.

Decomposition:
- Shared header sr_loader.vh: FSM state encodings, default SYNC_BYTE, byte-index width.
- One natural sub-module: sr_loader_timeout, a loadable down-counter with clear, enable and expiry-pulse output, reused by the future UART TX bootloader.

Test Plan:
- Load N=2: A5 02 00 13 05 10 00 93 05 20 00 CS.
  - rom_we at addr 0 data 0x00100513 one cycle after byte 0x00, then addr 1 data 0x00200593.
  - CS = XOR of the 8 data bytes.
  - done pulses; cpu_hold 1->0.
- Back-to-back bytes, rx_valid held high 12 consecutive cycles with the same frame -> identical writes, no dropped bytes.
- Bad checksum (CS^8'h01) -> no done, err=1, cpu_hold stays 1.
  - A following valid frame clears err, rewrites ROM, pulses done.
- Oversize: ADDR_W=2, A5 05 00 -> err=1 immediately after LEN_HI, zero rom_we pulses.
- Timeout: TIMEOUT=50; send A5 01 00 11 22 then silence -> err=1 at cycle 50 after last byte.
  - Bytes arriving afterwards that are not A5 are ignored.
- Reset mid-frame: rst during DATA -> all outputs 0 next cycle.
  - A fresh frame with N=0 (A5 00 00 00) -> done, no writes.
